// File: rtl/d_mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states
// and the request legality check used when a request arrives in IDLE.
package d_mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        FINISH  = 3'd4
    } state_e;

    // A request is refused when both directions are asked for, the size is
    // the reserved code, or the address is not naturally aligned for the size.
    function automatic logic is_rejected(
        input logic       ld,
        input logic       st,
        input size_e      sz,
        input logic [1:0] addr_lo
    );
        logic rej;
        rej = 1'b0;
        if (ld && st) begin
            rej = 1'b1;
        end else if (sz == SZ_ILLEGAL) begin
            rej = 1'b1;
        end else if (sz == SZ_HALF && addr_lo[0]) begin
            rej = 1'b1;
        end else if (sz == SZ_WORD && addr_lo != 2'b00) begin
            rej = 1'b1;
        end
        return rej;
    endfunction

endpackage

// File: rtl/d_mem_access_unit_if.sv
// CPU-side request/response and memory-side strobe bundle for the access unit.
// The slave modport is the unit itself; the master modport is the CPU+memory.
interface d_mem_access_unit_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
);
    logic                    load;
    logic                    store;
    logic [1:0]              size;
    logic                    unsigned_ld;
    logic [ADDRESS_BITS-1:0] address;
    logic [DATA_WIDTH-1:0]   store_data;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDRESS_BITS-1:0] mem_address;
    logic [DATA_WIDTH-1:0]   mem_in_data;
    logic [DATA_WIDTH-1:0]   mem_out_data;
    logic                    report;

    modport slave (
        input  load, store, size, unsigned_ld, address, store_data,
        input  mem_out_data, report,
        output busy, done, error, load_data,
        output mem_read, mem_write, mem_address, mem_in_data
    );

    modport master (
        output load, store, size, unsigned_ld, address, store_data,
        output mem_out_data, report,
        input  busy, done, error, load_data,
        input  mem_read, mem_write, mem_address, mem_in_data
    );
endinterface

// File: rtl/d_mem_access_unit_lane_align.sv
// Byte-lane datapath: extracts and sign/zero-extends the addressed lane of a
// memory word for loads, and merges store lanes into a read word for RMW.
module lsu_lane_align
    import d_mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  size_e                 i_size,
    input  logic                  i_unsigned_ld,
    input  logic [1:0]            i_lane,
    input  logic [DATA_WIDTH-1:0] i_mem_word,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    output logic [DATA_WIDTH-1:0] o_load_value,
    output logic [DATA_WIDTH-1:0] o_merged_word
);
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_store_rep;
    logic [LANES-1:0]      w_lane_en;

    // Bring the addressed lane down to bit 0 so extension is size-only.
    always_comb begin
        w_shifted = i_mem_word >> {i_lane, 3'b000};
    end

    // Extend the low byte/half; whole words pass straight through.
    always_comb begin
        o_load_value = i_mem_word;
        case (i_size)
            SZ_BYTE: o_load_value = {{(DATA_WIDTH-8){~i_unsigned_ld & w_shifted[7]}},
                                     w_shifted[7:0]};
            SZ_HALF: o_load_value = {{(DATA_WIDTH-16){~i_unsigned_ld & w_shifted[15]}},
                                     w_shifted[15:0]};
            default: o_load_value = i_mem_word;
        endcase
    end

    // Replicate the store value across lanes so each lane can pick it locally.
    always_comb begin
        w_store_rep = i_store_data;
        case (i_size)
            SZ_BYTE: w_store_rep = {LANES{i_store_data[7:0]}};
            SZ_HALF: w_store_rep = {(LANES/2){i_store_data[15:0]}};
            default: w_store_rep = i_store_data;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE_IDX = 2'(gi);
            assign w_lane_en[gi] = (i_size == SZ_BYTE) ? (LANE_IDX == i_lane) :
                                   (i_size == SZ_HALF) ? (LANE_IDX[1] == i_lane[1]) :
                                   1'b1;
            assign o_merged_word[gi*8 +: 8] = w_lane_en[gi] ? w_store_rep[gi*8 +: 8]
                                                             : i_mem_word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/d_mem_access_unit.sv
// Data-memory access unit: accepts one load/store at a time from the CPU,
// performs word accesses directly and sub-word stores as read-modify-write,
// with every output driven from a register.
module d_mem_access_unit
    import d_mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int CORE         = 0
) (
    input  logic                clock,
    input  logic                reset,
    d_mem_access_unit_if.slave  bus
);
    state_e                  r_state,        w_state_next;
    size_e                   r_size,         w_size_next;
    logic                    r_unsigned_ld,  w_unsigned_ld_next;
    logic                    r_is_load,      w_is_load_next;
    logic [1:0]              r_lane,         w_lane_next;
    logic [DATA_WIDTH-1:0]   r_store_data,   w_store_data_next;
    logic                    r_busy,         w_busy_next;
    logic                    r_done,         w_done_next;
    logic                    r_error,        w_error_next;
    logic                    r_mem_read,     w_mem_read_next;
    logic                    r_mem_write,    w_mem_write_next;
    logic [ADDRESS_BITS-1:0] r_mem_address,  w_mem_address_next;
    logic [DATA_WIDTH-1:0]   r_mem_in_data,  w_mem_in_data_next;
    logic [DATA_WIDTH-1:0]   r_load_data,    w_load_data_next;

    size_e                   w_req_size;
    logic [DATA_WIDTH-1:0]   w_load_value;
    logic [DATA_WIDTH-1:0]   w_merged_word;
    // The report strobe only drives simulation diagnostics for core CORE;
    // the hardware path deliberately ignores it.
    logic                    w_unused_report;

    assign w_req_size      = size_e'(bus.size);
    assign w_unused_report = bus.report;

    lsu_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .i_size        (r_size),
        .i_unsigned_ld (r_unsigned_ld),
        .i_lane        (r_lane),
        .i_mem_word    (bus.mem_out_data),
        .i_store_data  (r_store_data),
        .o_load_value  (w_load_value),
        .o_merged_word (w_merged_word)
    );

    // Next state plus the next value of every registered output.
    always_comb begin
        w_state_next       = r_state;
        w_size_next        = r_size;
        w_unsigned_ld_next = r_unsigned_ld;
        w_is_load_next     = r_is_load;
        w_lane_next        = r_lane;
        w_store_data_next  = r_store_data;
        w_mem_address_next = r_mem_address;
        w_mem_in_data_next = r_mem_in_data;
        w_load_data_next   = r_load_data;
        w_busy_next        = 1'b0;
        w_done_next        = 1'b0;
        w_error_next       = 1'b0;
        w_mem_read_next    = 1'b0;
        w_mem_write_next   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.load || bus.store) begin
                    w_busy_next = 1'b1;
                    if (is_rejected(bus.load, bus.store, w_req_size, bus.address[1:0])) begin
                        w_state_next = FINISH;
                        w_done_next  = 1'b1;
                        w_error_next = 1'b1;
                    end else begin
                        w_size_next        = w_req_size;
                        w_unsigned_ld_next = bus.unsigned_ld;
                        w_is_load_next     = bus.load;
                        w_lane_next        = bus.address[1:0];
                        w_store_data_next  = bus.store_data;
                        w_mem_address_next = {bus.address[ADDRESS_BITS-1:2], 2'b00};
                        if (bus.store && w_req_size == SZ_WORD) begin
                            // Full-word store needs no read: write and finish at once.
                            w_state_next       = WR;
                            w_mem_write_next   = 1'b1;
                            w_mem_in_data_next = bus.store_data;
                            w_done_next        = 1'b1;
                        end else begin
                            w_state_next    = RD;
                            w_mem_read_next = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                w_state_next = RD_WAIT;
                w_busy_next  = 1'b1;
            end
            RD_WAIT: begin
                // Memory word is valid now; finish a load or write back the merge.
                w_busy_next = 1'b1;
                w_done_next = 1'b1;
                if (r_is_load) begin
                    w_state_next     = FINISH;
                    w_load_data_next = w_load_value;
                end else begin
                    w_state_next       = WR;
                    w_mem_write_next   = 1'b1;
                    w_mem_in_data_next = w_merged_word;
                end
            end
            WR:      w_state_next = IDLE;
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, latched request and output registers; reset aborts any operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_size        <= SZ_BYTE;
            r_unsigned_ld <= 1'b0;
            r_is_load     <= 1'b0;
            r_lane        <= 2'b00;
            r_store_data  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_in_data <= '0;
            r_load_data   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_size        <= w_size_next;
            r_unsigned_ld <= w_unsigned_ld_next;
            r_is_load     <= w_is_load_next;
            r_lane        <= w_lane_next;
            r_store_data  <= w_store_data_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_error       <= w_error_next;
            r_mem_read    <= w_mem_read_next;
            r_mem_write   <= w_mem_write_next;
            r_mem_address <= w_mem_address_next;
            r_mem_in_data <= w_mem_in_data_next;
            r_load_data   <= w_load_data_next;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.error       = r_error;
    assign bus.load_data   = r_load_data;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_in_data = r_mem_in_data;

endmodule
